// File: rtl/fft_bitrev_reorder_pkg.sv
// ---------------------------------------------------------------------------
// fft_bitrev_reorder_pkg
// Shared types and helpers for the FFT output reorder stage.
//   rd_state_e : read-side FSM states (RD_IDLE, RD_BUSY)
//   bitrev()   : reverse the low nbits of an index (nbits <= MAX_LOG2N)
// ---------------------------------------------------------------------------
package fft_bitrev_reorder_pkg;

  // Largest supported frame is 1024 points.
  localparam int unsigned MAX_LOG2N = 10;

  typedef enum logic {
    RD_IDLE = 1'b0,
    RD_BUSY = 1'b1
  } rd_state_e;

  // Bits are shifted out of idx LSB-first and into r from the right, so after
  // nbits steps idx[0] sits at r[nbits-1]; bits above nbits stay zero.
  function automatic logic [MAX_LOG2N-1:0] bitrev(input logic [MAX_LOG2N-1:0] idx,
                                                  input int unsigned nbits);
    logic [MAX_LOG2N-1:0] r;
    logic [MAX_LOG2N-1:0] src;
    r   = '0;
    src = idx;
    for (int unsigned i = 0; i < MAX_LOG2N; i++) begin
      if (i < nbits) begin
        r   = (r << 1) | {{(MAX_LOG2N-1){1'b0}}, src[0]};
        src = src >> 1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_bitrev_reorder_ram.sv
// ---------------------------------------------------------------------------
// fft_bitrev_reorder_ram
// Simple dual-port RAM, one write port and one read port, both synchronous.
// The read data register is cleared by reset so that the block's data outputs
// read 0 in reset; the array itself is never reset.
//   clk, rst        : clock, async active-low reset (read register only)
//   i_en            : clock enable for both ports
//   i_we/i_waddr/i_wdata : write port
//   i_re/i_raddr    : read port, data appears on o_rdata the next cycle
//   o_rdata         : registered read data
// ---------------------------------------------------------------------------
module fft_bitrev_reorder_ram #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_en,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [2**ADDR_W];
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_en && i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rdata <= '0;
    end else if (i_en && i_re) begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/fft_bitrev_reorder.sv
// ---------------------------------------------------------------------------
// fft_bitrev_reorder
// Buffers frames arriving in bit-reversed order from the SDF FFT core and
// re-emits them in natural order X[0]..X[N-1] through a ping-pong pair of
// banks, so one-sample-per-cycle streaming needs no backpressure.
//
// Handshake: there is no ready. An input sample is taken when in_val && en;
// an output sample is delivered when out_val && en. en=0 freezes everything.
//
// Ports:
//   clk, rst (async, active-low), en (global clock enable)
//   in_val, in_sop, in_re, in_im    : input stream, bit-reversed index order
//   out_val, out_sop, out_eop, out_idx, out_re, out_im : natural-order stream
//   frame_drop      : one-cycle pulse when in_sop abandons a partial frame
//   o_dbg_rd_state  : current read FSM state
// ---------------------------------------------------------------------------
module fft_bitrev_reorder
  import fft_bitrev_reorder_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH = 16,
  parameter  int unsigned N_POINTS   = 16,
  localparam int unsigned LOG2N      = $clog2(N_POINTS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  in_val,
  input  logic                  in_sop,
  input  logic [DATA_WIDTH-1:0] in_re,
  input  logic [DATA_WIDTH-1:0] in_im,
  output logic                  out_val,
  output logic                  out_sop,
  output logic                  out_eop,
  output logic [LOG2N-1:0]      out_idx,
  output logic [DATA_WIDTH-1:0] out_re,
  output logic [DATA_WIDTH-1:0] out_im,
  output logic                  frame_drop,
  output rd_state_e             o_dbg_rd_state
);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] re;
    logic [DATA_WIDTH-1:0] im;
  } cplx_t;

  localparam logic [LOG2N-1:0] LAST_IDX = LOG2N'(N_POINTS - 1);

  logic [LOG2N-1:0] r_wr_cnt;
  logic             r_wr_bank;
  logic [1:0]       r_full;
  logic             r_frame_drop;
  rd_state_e        r_rd_state;
  logic [LOG2N-1:0] r_rd_cnt;
  logic             r_rd_bank;
  logic             r_out_val;
  logic             r_out_sop;
  logic             r_out_eop;
  logic [LOG2N-1:0] r_out_idx;

  logic             w_accept;
  logic             w_wr_last;
  logic             w_drop;
  logic             w_rd_issue;
  logic             w_rd_last;
  logic [LOG2N-1:0] w_wr_idx;
  logic [LOG2N-1:0] w_wr_addr;
  logic [LOG2N-1:0] w_rd_addr;
  logic [1:0]       w_full_set;
  logic [1:0]       w_full_clr;
  cplx_t            w_wdata;
  cplx_t            w_rdata;

  // ---------------- write side ----------------
  // in_sop forces the arrival index back to 0, so a resync writes address 0
  // and continues counting from 1 in the same bank.
  assign w_accept  = in_val && en;
  assign w_wr_idx  = in_sop ? '0 : r_wr_cnt;
  assign w_wr_addr = LOG2N'(bitrev(MAX_LOG2N'(w_wr_idx), LOG2N));
  assign w_wr_last = (w_wr_idx == LAST_IDX);
  assign w_drop    = w_accept && in_sop && (r_wr_cnt != '0);
  assign w_wdata   = cplx_t'{re: in_re, im: in_im};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_cnt     <= '0;
      r_wr_bank    <= 1'b0;
      r_frame_drop <= 1'b0;
    end else if (en) begin
      r_frame_drop <= w_drop;
      if (in_val) begin
        r_wr_cnt <= w_wr_last ? '0 : w_wr_idx + 1'b1;
        if (w_wr_last) begin
          r_wr_bank <= ~r_wr_bank;
        end
      end
    end
  end

  // ---------------- bank status ----------------
  // The writer only completes a bank whose full bit is clear and the reader
  // only clears a bank it is draining, so set and clear never hit one bank.
  assign w_full_set = (w_accept && w_wr_last) ? (r_wr_bank ? 2'b10 : 2'b01) : 2'b00;
  assign w_full_clr = w_rd_last ? (r_rd_bank ? 2'b10 : 2'b01) : 2'b00;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_full <= 2'b00;
    end else if (en) begin
      r_full <= (r_full & ~w_full_clr) | w_full_set;
    end
  end

  // ---------------- read side ----------------
  always_comb begin
    w_rd_issue = 1'b0;
    w_rd_addr  = r_rd_cnt;
    case (r_rd_state)
      RD_IDLE: begin
        w_rd_issue = r_full[r_rd_bank];
        w_rd_addr  = '0;
      end
      RD_BUSY: w_rd_issue = 1'b1;
      default: w_rd_issue = 1'b0;
    endcase
  end

  assign w_rd_last = w_rd_issue && (w_rd_addr == LAST_IDX);

  // Reader FSM plus the output flags, which are registered alongside the RAM
  // read so they line up with the read data one cycle after the issue.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_state <= RD_IDLE;
      r_rd_cnt   <= '0;
      r_rd_bank  <= 1'b0;
      r_out_val  <= 1'b0;
      r_out_sop  <= 1'b0;
      r_out_eop  <= 1'b0;
      r_out_idx  <= '0;
    end else if (en) begin
      r_out_val <= w_rd_issue;
      r_out_sop <= w_rd_issue && (w_rd_addr == '0);
      r_out_eop <= w_rd_last;
      r_out_idx <= w_rd_addr;
      case (r_rd_state)
        RD_IDLE: begin
          if (r_full[r_rd_bank]) begin
            r_rd_cnt   <= LOG2N'(1);
            r_rd_state <= RD_BUSY;
          end
        end
        RD_BUSY: begin
          if (r_rd_cnt == LAST_IDX) begin
            r_rd_cnt   <= '0;
            r_rd_bank  <= ~r_rd_bank;
            // Chain straight into the other bank when it is already waiting.
            r_rd_state <= r_full[~r_rd_bank] ? RD_BUSY : RD_IDLE;
          end else begin
            r_rd_cnt <= r_rd_cnt + 1'b1;
          end
        end
        default: r_rd_state <= RD_IDLE;
      endcase
    end
  end

  fft_bitrev_reorder_ram #(
    .DATA_W(2 * DATA_WIDTH),
    .ADDR_W(LOG2N + 1)
  ) u_ram (
    .clk    (clk),
    .rst    (rst),
    .i_en   (en),
    .i_we   (w_accept),
    .i_waddr({r_wr_bank, w_wr_addr}),
    .i_wdata(w_wdata),
    .i_re   (w_rd_issue),
    .i_raddr({r_rd_bank, w_rd_addr}),
    .o_rdata(w_rdata)
  );

  assign out_val        = r_out_val;
  assign out_sop        = r_out_sop;
  assign out_eop        = r_out_eop;
  assign out_idx        = r_out_idx;
  assign out_re         = w_rdata.re;
  assign out_im         = w_rdata.im;
  assign frame_drop     = r_frame_drop;
  assign o_dbg_rd_state = r_rd_state;

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// ---------------------------------------------------------------------------
// tb_fft_bitrev_reorder
// Self-checking bench for the natural-order reorder stage with N=16.
// Reference model: each frame is generated as a natural-order array X[0..15],
// sent as X[bitrev(k)] for arrival k, and expected back as X[0..15].
// ---------------------------------------------------------------------------
module tb_fft_bitrev_reorder;
  import fft_bitrev_reorder_pkg::*;

  localparam int DW    = 16;
  localparam int NP    = 16;
  localparam int EXP_W = 4 + 2 * DW;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  logic en;
  logic in_val;
  logic in_sop;
  logic [DW-1:0] in_re;
  logic [DW-1:0] in_im;
  logic out_val;
  logic out_sop;
  logic out_eop;
  logic [3:0] out_idx;
  logic [DW-1:0] out_re;
  logic [DW-1:0] out_im;
  logic frame_drop;
  rd_state_e dbg_rd_state;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  fft_bitrev_reorder #(.DATA_WIDTH(DW), .N_POINTS(NP)) dut (
    .clk           (clk),
    .rst           (rst),
    .en            (en),
    .in_val        (in_val),
    .in_sop        (in_sop),
    .in_re         (in_re),
    .in_im         (in_im),
    .out_val       (out_val),
    .out_sop       (out_sop),
    .out_eop       (out_eop),
    .out_idx       (out_idx),
    .out_re        (out_re),
    .out_im        (out_im),
    .frame_drop    (frame_drop),
    .o_dbg_rd_state(dbg_rd_state)
  );

  // ---------------- bookkeeping ----------------
  int errors = 0;
  int checks = 0;
  int drop_cnt = 0;
  bit sb_on = 1'b0;
  logic [EXP_W-1:0] exp_q[$];
  logic [EXP_W-1:0] sb_e;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int bitrev4(input int k);
    int r;
    r = 0;
    for (int b = 0; b < 4; b++) r = r | (((k >> b) & 1) << (3 - b));
    return r;
  endfunction

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (rst && en && sb_on && out_val) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: got idx %0d re 0x%0h, expected no output", out_idx, out_re);
      end else begin
        sb_e = exp_q.pop_front();
        chk("sb_idx", out_idx, sb_e[35:32]);
        chk("sb_re",  out_re,  sb_e[31:16]);
        chk("sb_im",  out_im,  sb_e[15:0]);
        chk("sb_sop", out_sop, (sb_e[35:32] == 4'd0));
        chk("sb_eop", out_eop, (sb_e[35:32] == 4'd15));
      end
    end
  end

  always @(negedge clk) begin
    if (rst && en && frame_drop) drop_cnt++;
  end

  // A write into a bank still waiting to be read would corrupt it.
  always @(negedge clk) begin
    if (rst && en && in_val && dut.r_full[dut.r_wr_bank]) begin
      checks++;
      errors++;
      $display("FAIL write_to_full: got write into bank %0d with full=1, expected none", dut.r_wr_bank);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle();
    @(posedge clk); #1;
    in_val = 1'b0;
    in_sop = 1'b0;
  endtask

  task automatic send_frame(input bit gapped, input bit rand_gap, input bit sop);
    logic [DW-1:0] xr[NP];
    logic [DW-1:0] xi[NP];
    for (int j = 0; j < NP; j++) begin
      xr[j] = 16'($urandom);
      xi[j] = 16'($urandom);
      exp_q.push_back({4'(j), xr[j], xi[j]});
    end
    for (int k = 0; k < NP; k++) begin
      if (rand_gap) begin
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk); #1;
          in_val = 1'b0;
          in_sop = 1'b0;
        end
      end
      @(posedge clk); #1;
      in_val = 1'b1;
      in_sop = sop && (k == 0);
      in_re  = xr[bitrev4(k)];
      in_im  = xi[bitrev4(k)];
      if (gapped) begin
        @(posedge clk); #1;
        in_val = 1'b0;
        in_sop = 1'b0;
      end
    end
  endtask

  task automatic measure_run(output int len);
    int w;
    len = 0;
    w = 0;
    @(negedge clk);
    while (!(out_val && en) && w < 300) begin
      @(negedge clk);
      w++;
    end
    while (out_val && en && len < 300) begin
      len++;
      @(negedge clk);
    end
  endtask

  task automatic wait_drain(input string name);
    int w;
    w = 0;
    while (exp_q.size() != 0 && w < 200) begin
      @(negedge clk);
      w++;
    end
    chk(name, exp_q.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  // ---------------- directed vector table (test 1) ----------------
  typedef struct {
    logic [DW-1:0] in_re;
    logic [DW-1:0] in_im;
    logic [3:0]    exp_idx;
    logic [DW-1:0] exp_re;
    logic [DW-1:0] exp_im;
    logic          exp_sop;
    logic          exp_eop;
  } vec_t;

  vec_t vecs[NP];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int run_a;
    int run_b;
    int d0;
    int nval;
    bit found;
    bit hit;

    for (int k = 0; k < NP; k++) begin
      vecs[k].in_re   = 16'(bitrev4(k));
      vecs[k].in_im   = 16'(0 - bitrev4(k));
      vecs[k].exp_idx = 4'(k);
      vecs[k].exp_re  = 16'(k);
      vecs[k].exp_im  = 16'(0 - k);
      vecs[k].exp_sop = (k == 0);
      vecs[k].exp_eop = (k == NP - 1);
    end

    rst = 1'b1; en = 1'b1; in_val = 1'b0; in_sop = 1'b0; in_re = '0; in_im = '0;
    #2 rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_out_val", out_val, 0);
    chk("rst_out_sop", out_sop, 0);
    chk("rst_out_eop", out_eop, 0);
    chk("rst_out_idx", out_idx, 0);
    chk("rst_out_re", out_re, 0);
    chk("rst_out_im", out_im, 0);
    chk("rst_frame_drop", frame_drop, 0);
    chk("rst_rd_state", dbg_rd_state, RD_IDLE);
    @(negedge clk);
    rst = 1'b1;

    // Test 1: single frame, table-driven, exact latency
    for (int k = 0; k < NP; k++) begin
      @(posedge clk); #1;
      in_val = 1'b1;
      in_re  = vecs[k].in_re;
      in_im  = vecs[k].in_im;
    end
    idle();
    @(negedge clk);
    chk("t1_lat_t1_val", out_val, 0);
    for (int j = 0; j < NP; j++) begin
      @(negedge clk);
      chk("t1_val", out_val, 1);
      chk("t1_idx", out_idx, vecs[j].exp_idx);
      chk("t1_re",  out_re,  vecs[j].exp_re);
      chk("t1_im",  out_im,  vecs[j].exp_im);
      chk("t1_sop", out_sop, vecs[j].exp_sop);
      chk("t1_eop", out_eop, vecs[j].exp_eop);
    end
    @(negedge clk);
    chk("t1_after_val", out_val, 0);
    chk("t1_no_drop", drop_cnt, 0);

    sb_on = 1'b1;

    // Test 2: three back-to-back frames, one unbroken 48-sample run
    fork
      begin
        send_frame(0, 0, 0);
        send_frame(0, 0, 0);
        send_frame(0, 0, 0);
        idle();
      end
      measure_run(run_a);
    join
    chk("t2_run_len", run_a, 48);
    wait_drain("t2_drain");

    // Test 3: 50% duty input, each frame a contiguous 16-sample run
    fork
      begin
        send_frame(1, 0, 0);
        send_frame(1, 0, 0);
        idle();
      end
      begin
        measure_run(run_a);
        measure_run(run_b);
      end
    join
    chk("t3_run0_len", run_a, 16);
    chk("t3_run1_len", run_b, 16);
    wait_drain("t3_drain");

    // Test 4: en low for several cycles in the middle of a read
    send_frame(0, 0, 0);
    idle();
    found = 1'b0;
    for (int w = 0; w < 60 && !found; w++) begin
      @(negedge clk);
      if (out_val && out_idx == 4'd7) found = 1'b1;
    end
    chk("t4_found_idx7", found, 1);
    @(posedge clk); #1;
    en = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("t4_hold_val", out_val, 1);
      chk("t4_hold_idx", out_idx, 8);
      chk("t4_hold_re", out_re, exp_q[0][31:16]);
    end
    @(posedge clk); #1;
    en = 1'b1;
    wait_drain("t4_drain");

    // Test 5: partial frame abandoned by in_sop
    d0 = drop_cnt;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      in_val = 1'b1;
      in_sop = (k == 0);
      in_re  = 16'($urandom);
      in_im  = 16'($urandom);
    end
    send_frame(0, 0, 1);
    idle();
    wait_drain("t5_drain");
    repeat (5) @(negedge clk);
    chk("t5_drop_count", drop_cnt - d0, 1);
    chk("t5_left", exp_q.size(), 0);

    // Test 6: reset while reading frame A and writing frame B
    send_frame(0, 0, 0);
    hit = 1'b0;
    for (int k = 0; k < NP && !hit; k++) begin
      @(posedge clk); #1;
      in_val = 1'b1;
      in_sop = 1'b0;
      in_re  = 16'($urandom);
      in_im  = 16'($urandom);
      @(negedge clk);
      if (out_val && out_idx == 4'd10) hit = 1'b1;
    end
    chk("t6_reached_idx10", hit, 1);
    rst = 1'b0;
    in_val = 1'b0;
    exp_q.delete();
    #1;
    chk("t6_rst_val", out_val, 0);
    chk("t6_rst_idx", out_idx, 0);
    chk("t6_rst_re", out_re, 0);
    chk("t6_rst_im", out_im, 0);
    chk("t6_rst_sop", out_sop, 0);
    chk("t6_rst_eop", out_eop, 0);
    chk("t6_rst_drop", frame_drop, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    nval = 0;
    repeat (20) begin
      @(negedge clk);
      if (out_val) nval++;
    end
    chk("t6_no_stale", nval, 0);
    send_frame(0, 0, 0);
    idle();
    wait_drain("t6_drain");

    // Test 7: random arrival gaps over several frames
    for (int f = 0; f < 4; f++) send_frame(0, 1, 0);
    idle();
    wait_drain("t7_drain");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fft_bitrev_reorder.md
Name: fft_bitrev_reorder

Overview:
- Output reorder stage placed directly downstream of the radix-2^2 SDF FFT core.
- The core emits each N-point frame in bit-reversed index order. This block buffers the frame and re-emits it in natural order (X[0]..X[N-1]).
- Uses a ping-pong pair of RAM banks, so continuous one-sample-per-cycle streaming runs without gaps or backpressure.

Parameters:
- DATA_WIDTH, 16, width of each real/imag sample.
- N_POINTS, 16, FFT frame length; power of 2, 4..1024.
- LOG2N (localparam), $clog2(N_POINTS), index/counter width.

Ports:
- clk, input, 1, clock.
- rst, input, 1, asynchronous, active-low reset.
- en, input, 1, global clock enable; en=0 freezes all state.
- in_val, input, 1, input sample valid (FFT core output valid).
- in_sop, input, 1, marks the first sample of a frame; optional resync.
- in_re, input, DATA_WIDTH, input real part (bit-reversed order).
- in_im, input, DATA_WIDTH, input imaginary part.
- out_val, output, 1, output sample valid.
- out_sop, output, 1, high with natural index 0.
- out_eop, output, 1, high with natural index N-1.
- out_idx, output, LOG2N, natural frequency index of the output sample.
- out_re, output, DATA_WIDTH, output real part.
- out_im, output, DATA_WIDTH, output imaginary part.
- frame_drop, output, 1, one-cycle pulse when a partial frame is discarded by in_sop.

Behaviour:
- Reset (rst=0, async):
  - All outputs are 0.
  - wr_cnt=0, wr_bank=0, full[1:0]=0, reader in RD_IDLE, rd_cnt=0.
  - RAM contents are not reset.
  - Reset mid-frame discards all buffered data; no partial output is emitted after release.
- en=0: no register or RAM changes; outputs hold. The consumer qualifies samples with out_val && en.
- Write side (accept = in_val && en):
  - Store {in_re,in_im} at address bitrev(wr_cnt) in bank wr_bank; wr_cnt increments.
  - On accept with wr_cnt==N-1: wr_cnt wraps to 0, full[wr_bank] is set and wr_bank toggles, all on the same edge.
  - Accept with in_sop=1: write at address 0, wr_cnt becomes 1.
  - If wr_cnt was nonzero at that accept, the partial frame is abandoned (bank not marked full) and frame_drop pulses in the next cycle.
  - in_sop with wr_cnt==0 is a normal frame start.
  - Samples without in_sop are framed free-running by wr_cnt.
- Read side FSM (advances only when en=1):
  - RD_IDLE: if full[rd_bank], issue read of rd_addr=0 this cycle, rd_cnt becomes 1, go to RD_BUSY.
  - RD_BUSY: issue read of rd_cnt each cycle.
    - On issuing N-1: clear full[rd_bank], toggle rd_bank.
    - If the other bank is already full, continue directly (stay in RD_BUSY with rd_cnt=0); otherwise go to RD_IDLE.
- Latency:
  - Cycle t accepts the last sample of a frame.
  - The read of index 0 issues at t+1 (synchronous RAM).
  - Output registers present out_val=1, out_idx=0, out_sop=1 in cycle t+2.
  - N consecutive valid outputs follow (en=1); out_eop=1 with idx N-1.
- Throughput: continuous input at 1 sample/cycle yields continuous output with no bubbles, 2 cycles after each frame completes.
- Collision freedom:
  - The writer needs at least N accepts per bank and the reader issues exactly N reads per bank, so the writer never enters a bank with full=1.
  - The bench asserts this: a write to a full bank is a design error.
- The same bank address is never read and written in the same cycle.
- Arithmetic: pure data movement, no scaling or rounding; out_re/out_im are bit-exact to the input.

Decomposition:
- fft_pkg:
  - bitrev(idx, LOG2N) function.
  - cplx_t struct {re, im} parameterised by DATA_WIDTH (via typedef in the module).
  - rd_state_e {RD_IDLE, RD_BUSY}.
- Sub-module fft_reorder_ram:
  - Simple dual-port RAM, 2*N_POINTS entries of 2*DATA_WIDTH bits.
  - Address = {bank, index}; synchronous write, synchronous read, clock enable en.

Test Plan (N_POINTS=16):
1. Reset, then 16 contiguous samples re=k, im=-k in arrival order k=0..15. The arrival sequence carries values for indices 0,8,4,12,2,...; expect output re=0..15 with out_idx==re, sop at idx 0, eop at idx 15. First out_val arrives 2 cycles after the 16th input.
2. Three back-to-back frames at 1 sample/cycle -> 48 contiguous out_val cycles, no bubbles, frames in order, no write-to-full assertion fires.
3. Input with in_val toggling 1/0 (50% duty) -> each frame emitted as 16 contiguous outputs; the read of frame n completes before frame n+1's write finishes.
4. en deasserted for 5 cycles mid-read (at idx 7) -> outputs hold; after en returns, idx 8..15 continue with correct data, no duplicates counted.
5. in_sop after 5 samples, then a full 16-sample frame -> frame_drop pulses once; only the full frame is output (16 samples), the partial 5 never appear.
6. rst asserted at idx 10 of an output frame while the next frame is half written -> outputs 0 immediately. After release, a new 16-sample frame is output correctly and no stale data is emitted.
